// File: rtl/plru_hit_tracker32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plru_pkg
//  Description : Shared types, constants and helper functions for the
//                32-way pseudo-LRU hit tracker.
//                - plru_state_t : handshake/update FSM states
//                - onehot_to_idx: one-hot vector to binary index
//                - is_onehot    : true when exactly one bit is set
//                The helpers work on WAYS_DEFAULT-bit vectors. Narrower
//                vectors are zero-extended by the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
package plru_pkg;

    localparam int WAYS_DEFAULT = 32;
    localparam int TREE_BITS    = WAYS_DEFAULT - 1;
    localparam int IDX_DEFAULT  = $clog2(WAYS_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_ACK    = 3'd4
    } plru_state_t;

    // OR-of-indices encoder. Exact only for one-hot input, which the FSM
    // guarantees before the result is used.
    function automatic logic [IDX_DEFAULT-1:0] onehot_to_idx(
        input logic [WAYS_DEFAULT-1:0] vec
    );
        logic [IDX_DEFAULT-1:0] idx;
        idx = '0;
        for (int i = 0; i < WAYS_DEFAULT; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_DEFAULT'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [WAYS_DEFAULT-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_hit_tracker32_if.sv
`default_nettype none
// ============================================================================
//  Module      : plru_hit_tracker32_if
//  Description : Request/acknowledge and status bundle of the PLRU hit
//                tracker.
//                i_req     : one-hot request level from the mutex merge
//                o_free    : 4-phase acknowledge back to the merge
//                o_upd     : one-cycle PLRU update pulse
//                o_hit_idx : way of the last accepted request
//                o_victim  : current PLRU victim way
//                o_err     : sticky non-one-hot request flag
//                o_hit_cnt : saturating count of updates
//                Modport slave is the tracker, master is the merge side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface plru_hit_tracker32_if #(
    parameter int WAYS  = 32,
    parameter int IDX_W = $clog2(WAYS),
    parameter int CNT_W = 16
);
    logic [WAYS-1:0]  i_req;
    logic             o_free;
    logic             o_upd;
    logic [IDX_W-1:0] o_hit_idx;
    logic [IDX_W-1:0] o_victim;
    logic             o_err;
    logic [CNT_W-1:0] o_hit_cnt;

    modport slave (
        input  i_req,
        output o_free, o_upd, o_hit_idx, o_victim, o_err, o_hit_cnt
    );

    modport master (
        output i_req,
        input  o_free, o_upd, o_hit_idx, o_victim, o_err, o_hit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : plru_tree
//  Description : Tree pseudo-LRU state for one set. Node n has children
//                2n+1 / 2n+2; a 0 bit points the victim to the lower half.
//                Ports:
//                clk, rst     : clock, synchronous active-high reset
//                i_upd_en     : apply an access to way i_upd_idx this edge
//                i_upd_idx    : accessed way
//                o_victim     : registered victim, walked from the tree
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_tree #(
    parameter int WAYS  = 32,
    parameter int IDX_W = $clog2(WAYS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_upd_en,
    input  wire logic [IDX_W-1:0] i_upd_idx,
    output logic      [IDX_W-1:0] o_victim
);

    logic [WAYS-2:0]  r_tree;
    logic [WAYS-2:0]  w_tree_next;
    logic [IDX_W-1:0] r_victim;

    function automatic logic [IDX_W-1:0] walk(input logic [WAYS-2:0] tree);
        logic [IDX_W-1:0] v;
        int               node;
        v    = '0;
        node = 0;
        for (int l = 0; l < IDX_W; l++) begin
            v[IDX_W-1-l] = tree[node];
            node         = 2 * node + 1 + int'(tree[node]);
        end
        return v;
    endfunction

    // At depth l the node on the path is (2^l - 1) + (top l bits of idx);
    // it is pointed away from the half that the access fell into.
    always_comb begin
        int node;
        w_tree_next = r_tree;
        node        = 0;
        if (i_upd_en) begin
            for (int l = 0; l < IDX_W; l++) begin
                node = (1 << l) - 1 + int'(i_upd_idx >> (IDX_W - l));
                w_tree_next[node] = ~i_upd_idx[IDX_W-1-l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tree   <= '0;
            r_victim <= '0;
        end else begin
            r_tree   <= w_tree_next;
            r_victim <= walk(r_tree);
        end
    end

    assign o_victim = r_victim;

endmodule
`default_nettype wire

// File: rtl/plru_hit_tracker32.sv
`default_nettype none
// ============================================================================
//  Module      : plru_hit_tracker32
//  Description : Clocked consumer of the 32-input asynchronous mutex merge.
//                Synchronises the held one-hot request, waits for it to
//                settle, updates the tree PLRU and returns a 4-phase
//                acknowledge.
//                Ports:
//                clk, rst : clock, synchronous active-high reset
//                bus      : plru_hit_tracker32_if.slave (request, ack, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_hit_tracker32
    import plru_pkg::*;
#(
    parameter int WAYS        = 32,
    parameter int IDX_W       = $clog2(WAYS),
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    plru_hit_tracker32_if.slave   bus
);

    logic [WAYS-1:0]  r_sync [SYNC_STAGES];
    logic [WAYS-1:0]  w_req_s;
    plru_state_t      r_state;
    plru_state_t      w_state_next;
    logic [WAYS-1:0]  r_cap;
    logic [WAYS-1:0]  w_cap_next;
    logic             w_set_err;
    logic             w_do_upd;
    logic [IDX_W-1:0] w_enc;
    logic             r_free;
    logic             r_upd;
    logic [IDX_W-1:0] r_hit_idx;
    logic             r_err;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [IDX_W-1:0] w_victim;

    // Plain flop chain per bit; the raw input feeds the first flop directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.i_req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_enc   = IDX_W'(onehot_to_idx(WAYS_DEFAULT'(r_cap)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cap   <= w_cap_next;
        end
    end

    // The request must read identically on two consecutive cycles before it
    // is trusted, since the merge output can glitch while it transitions.
    always_comb begin
        w_state_next = r_state;
        w_cap_next   = r_cap;
        w_set_err    = 1'b0;
        w_do_upd     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s != '0) begin
                    w_cap_next   = w_req_s;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_req_s == r_cap) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_cap_next   = w_req_s;
                    w_state_next = (w_req_s == '0) ? ST_IDLE : ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (is_onehot(WAYS_DEFAULT'(r_cap))) begin
                    w_state_next = ST_UPDATE;
                end else begin
                    w_set_err    = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_UPDATE: begin
                w_do_upd     = 1'b1;
                w_state_next = ST_ACK;
            end
            ST_ACK: begin
                // A different nonzero value here is a protocol violation
                // and is deliberately ignored.
                if (w_req_s == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_free    <= 1'b0;
            r_upd     <= 1'b0;
            r_hit_idx <= '0;
            r_err     <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            r_free <= (w_state_next == ST_ACK);
            r_upd  <= w_do_upd;
            if (w_do_upd) begin
                r_hit_idx <= w_enc;
                if (r_hit_cnt != '1) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    plru_tree #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .i_upd_en  (w_do_upd),
        .i_upd_idx (w_enc),
        .o_victim  (w_victim)
    );

    assign bus.o_free    = r_free;
    assign bus.o_upd     = r_upd;
    assign bus.o_hit_idx = r_hit_idx;
    assign bus.o_victim  = w_victim;
    assign bus.o_err     = r_err;
    assign bus.o_hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: doc/plru_hit_tracker32.md
Name: plru_hit_tracker32

Overview:
- Synchronous consumer placed directly downstream of the 32-input asynchronous mutex merge.
- Takes the merge's one-hot request vector (o_data), which is a level held until acknowledged, and synchronises it into the clock domain.
- Encodes the winning way and updates a 31-bit tree pseudo-LRU for a 32-way set.
- Returns a 4-phase acknowledge that drives the merge's i_freeNext, and publishes the current victim way.

Parameters:
- WAYS, 32, number of ways (power of two, ≥2).
- IDX_W, $clog2(WAYS), width of way index.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (≥2).
- CNT_W, 16, width of the saturating update counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: synchronous, active-high. All state is cleared on the clk edge where rst=1.
- i_req  in  WAYS  asynchronous one-hot request level from the merge (its o_data). Not glitch-free across transitions.
- o_free  out  1  acknowledge to the merge's i_freeNext. Registered; held until the request drops.
- o_upd  out  1  one-cycle pulse: the PLRU was updated this cycle.
- o_hit_idx  out  IDX_W  encoded way of the last accepted request. Valid from the o_upd cycle, held until the next update.
- o_victim  out  IDX_W  current PLRU victim. Registered; recomputed from the tree every cycle.
- o_err  out  1  sticky: a settled request that was not one-hot was seen. Cleared only by rst.
- o_hit_cnt  out  CNT_W  count of valid updates. Saturates at all-ones.

Behaviour:
- Reset values: o_free=0, o_upd=0, o_hit_idx=0, o_victim=0, o_err=0, o_hit_cnt=0. Tree bits all 0. Synchroniser flops all 0. State=IDLE.
- Synchroniser: each bit of i_req passes through SYNC_STAGES flops, giving req_s. No logic is placed before the first flop.
- Tree: node n has children 2n+1 and 2n+2; the root is node 0.
  - Bit=0: victim lies in the lower-index half. Bit=1: victim lies in the upper half.
  - Access to way w: every node on w's path is set to point away from w (lower half accessed → 1, upper half accessed → 0). Nodes off the path are unchanged.
- o_victim: follow the bits from the root, registered. It reflects an update one cycle after the o_upd pulse.
- FSM:
  - IDLE, o_free=0. If req_s≠0: cap←req_s, go to SETTLE.
  - SETTLE. If req_s==cap: go to CHECK. Else: cap←req_s, stay in SETTLE; if req_s==0, go to IDLE instead.
  - CHECK:
    - cap one-hot → UPDATE.
    - Otherwise (multiple bits set) → o_err←1 and go to ACK, with no tree change, no o_upd and no count.
  - UPDATE (1 cycle): tree updated; o_hit_idx←encode(cap); o_upd=1; o_hit_cnt+=1 unless saturated; go to ACK.
  - ACK, o_free=1. Stay while req_s≠0. When req_s==0: o_free←0, go to IDLE.
- Latency: i_req rises before edge k → req_s valid at edge k+SYNC_STAGES−1 → SETTLE, CHECK, UPDATE → o_free asserted 4 cycles after req_s first becomes nonzero.
- Only one request is in flight: the merge guarantees mutual exclusion, and the block does not sample a new request until it has returned to IDLE.
- A new request arriving while in ACK is impossible by protocol. If req_s changes to a different nonzero value while in ACK, the block stays in ACK and the value is ignored.
- rst mid-operation: on the next edge the outputs are cleared, the tree is cleared and the FSM goes to IDLE. A request still held high afterwards is treated as a new request.
- o_hit_cnt at all-ones: holds; o_upd still pulses.

Decomposition:
- Shared package plru_pkg:
  - FSM state enum (IDLE, SETTLE, CHECK, UPDATE, ACK).
  - Function onehot_to_idx.
  - Function is_onehot.
  - Constants WAYS_DEFAULT=32 and TREE_BITS=WAYS−1.
- One sub-module, plru_tree: holds the tree register. Inputs: update enable and index. Output: victim. Combinational path-update logic plus the register.
- Top module: synchroniser, FSM, counter and error flag.

Test Plan:
- Reset then idle → o_victim=0, o_free=0, o_hit_cnt=0, tree=0.
- i_req=32'h1 held until o_free, then released → o_upd pulses once, o_hit_idx=0, o_victim=16, o_free=1 until req_s=0, then 0, o_hit_cnt=1.
- Request way 0, then way 16, each with full handshake → after the second, o_hit_idx=16, o_victim=8, o_hit_cnt=2.
- i_req=32'h0000_0101 held → o_err=1, no o_upd, o_victim unchanged, o_free still asserted and released after i_req=0.
- i_req glitching 32'h4 → 32'h8 over consecutive cycles then stable at 32'h8 → single update, o_hit_idx=3.
- Assert rst while in ACK with i_req=32'h80000000 held → all outputs reset next cycle. After rst drops, the request is re-accepted: o_hit_idx=31, o_victim=0, o_hit_cnt=1.
